// File: rtl/piso_tx_pkg.sv
// Shared types and line levels for the framed PISO transmitter.
package piso_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Counter width for a 0..n-1 count, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piso_bit_timer.sv
// Baud timer: counts 0..CLKS_PER_BIT-1 and flags the last count as the bit tick.
module piso_bit_timer
  import piso_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned TMR_W = cnt_width(CLKS_PER_BIT);
  localparam logic [TMR_W-1:0] LAST = TMR_W'(CLKS_PER_BIT - 1);

  logic [TMR_W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear || tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + TMR_W'(1);
    end
  end

  // With CLKS_PER_BIT=1 the count stays at 0 == LAST, so every clock ticks.
  assign tick = (r_count == LAST);

endmodule

// File: rtl/piso_frame_tx.sv
// Framed PISO transmitter: start bit, LSB-first data, optional even parity, stop bit.
module piso_frame_tx
  import piso_tx_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          PARITY_EN    = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IDX_W = cnt_width(WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic             r_parity, w_parity_nxt;
  logic             r_serial, w_serial_nxt;
  logic             r_busy;
  logic             r_ready;
  logic             r_done, w_done_nxt;
  logic             w_tick;
  logic             w_timer_clear;

  // Timer is held at zero while idle so the start bit gets a full bit period.
  assign w_timer_clear = (r_state == IDLE);

  piso_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .reset(reset),
    .clear(w_timer_clear),
    .tick (w_tick)
  );

  // Next-state, datapath and next output levels.
  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_idx_nxt    = r_idx;
    w_parity_nxt = r_parity;
    w_done_nxt   = 1'b0;
    w_serial_nxt = IDLE_LEVEL;

    case (r_state)
      IDLE: begin
        if (load_valid) begin
          w_shreg_nxt  = parallel_in;
          w_parity_nxt = ^parallel_in;
          w_idx_nxt    = '0;
          w_state_nxt  = START;
        end
      end
      START: begin
        if (w_tick) begin
          w_idx_nxt   = '0;
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shreg_nxt = r_shreg >> 1;
          if (r_idx == IDX_LAST) begin
            w_idx_nxt   = '0;
            w_state_nxt = PARITY_EN ? PARITY : STOP;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (w_tick) begin
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (w_tick) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Line level is registered from the next state so it changes with the state.
    case (w_state_nxt)
      START:   w_serial_nxt = START_LEVEL;
      DATA:    w_serial_nxt = w_shreg_nxt[0];
      PARITY:  w_serial_nxt = w_parity_nxt;
      STOP:    w_serial_nxt = STOP_LEVEL;
      default: w_serial_nxt = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_idx    <= '0;
      r_parity <= 1'b0;
      r_serial <= IDLE_LEVEL;
      r_busy   <= 1'b0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shreg  <= w_shreg_nxt;
      r_idx    <= w_idx_nxt;
      r_parity <= w_parity_nxt;
      r_serial <= w_serial_nxt;
      r_busy   <= (w_state_nxt != IDLE);
      r_ready  <= (w_state_nxt == IDLE);
      r_done   <= w_done_nxt;
    end
  end

  assign load_ready = r_ready;
  assign serial_out = r_serial;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_piso_frame_tx.sv
// Bench for piso_frame_tx: parity-on (dut0) and parity-off (dut1) instances vs a frame-level model.
module tb_piso_frame_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       lv0, lv1;
  logic [7:0] pin0, pin1;
  logic       so0, so1, rdy0, rdy1, bsy0, bsy1, dn0, dn1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         d;
    logic [7:0] w;
    int         exp_len;
    logic       exp_par;
  } vec_t;

  always #5 clk = ~clk;

  piso_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut0 (
    .clk(clk), .reset(reset), .parallel_in(pin0), .load_valid(lv0),
    .load_ready(rdy0), .serial_out(so0), .busy(bsy0), .done(dn0)
  );

  piso_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut1 (
    .clk(clk), .reset(reset), .parallel_in(pin1), .load_valid(lv1),
    .load_ready(rdy1), .serial_out(so1), .busy(bsy1), .done(dn1)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] stat(input int d);
    return (d == 0) ? {so0, bsy0, rdy0, dn0} : {so1, bsy1, rdy1, dn1};
  endfunction

  task automatic set_in(input int d, input logic v, input logic [7:0] w);
    if (d == 0) begin lv0 = v; pin0 = w; end
    else        begin lv1 = v; pin1 = w; end
  endtask

  // Frame model: bit slot i/CPB -> start, data LSB first, optional even parity, stop.
  function automatic logic model_level(input logic [7:0] w, input bit pe, input int i);
    int slot;
    slot = i / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return w[slot-1];
    if (pe && slot == 9) return ^w;
    return 1'b1;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the done cycle.
  task automatic frame(input int d, input logic [7:0] w, input bit scramble,
                       output int len, output logic par);
    bit pe;
    int flen;
    logic [3:0] s;
    pe   = (d == 0);
    flen = (2 + 8 + (pe ? 1 : 0)) * CPB;
    par  = 1'bx;
    s = stat(d);
    chk("ready_before_load", 32'(s[1]), 32'd1);
    set_in(d, 1'b1, w);
    @(negedge clk);
    if (!scramble) set_in(d, 1'b0, ~w);
    len = 0;
    s = stat(d);
    while (s[0] !== 1'b1 && len < 200) begin
      if (len < flen) chk("serial_bit", 32'(s[3]), 32'(model_level(w, pe, len)));
      else            chk("frame_overrun", 32'(len), 32'(flen));
      chk("busy_ready_done", 32'(s[2:0]), 32'b100);
      if (pe && len == 9*CPB + CPB/2) par = s[3];
      if (scramble) set_in(d, 1'($urandom_range(0, 1)), 8'($urandom));
      len++;
      @(negedge clk);
      s = stat(d);
    end
    if (len >= 200) chk("done_timeout", 32'd0, 32'd1);
    chk("done_cycle", 32'(s), 32'b1011);
    set_in(d, 1'b0, 8'h00);
  endtask

  task automatic idle(input int d, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("idle_state", 32'(stat(d)), 32'b1010);
    end
  endtask

  initial begin
    vec_t tbl[8];
    int   len;
    logic par;
    int   d;
    logic [7:0] w;

    tbl[0] = '{0, 8'hA5, 44, 1'b0};
    tbl[1] = '{0, 8'h07, 44, 1'b1};
    tbl[2] = '{1, 8'h07, 40, 1'b0};
    tbl[3] = '{0, 8'h00, 44, 1'b0};
    tbl[4] = '{0, 8'h01, 44, 1'b1};
    tbl[5] = '{0, 8'hFF, 44, 1'b0};
    tbl[6] = '{1, 8'hA5, 40, 1'b0};
    tbl[7] = '{0, 8'h80, 44, 1'b1};

    reset = 1'b1;
    set_in(0, 1'b0, 8'h00);
    set_in(1, 1'b0, 8'h00);
    @(negedge clk);
    chk("reset_dut0", 32'(stat(0)), 32'b1010);
    chk("reset_dut1", 32'(stat(1)), 32'b1010);
    reset = 1'b0;

    // Idle after reset: line high, ready, never done.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("post_reset_idle0", 32'(stat(0)), 32'b1010);
      chk("post_reset_idle1", 32'(stat(1)), 32'b1010);
    end

    for (int i = 0; i < 8; i++) begin
      frame(tbl[i].d, tbl[i].w, 1'b0, len, par);
      chk("frame_len", 32'(len), 32'(tbl[i].exp_len));
      if (tbl[i].d == 0) chk("parity_bit", 32'(par), 32'(tbl[i].exp_par));
      idle(tbl[i].d, 1);
    end

    // Back-to-back: second word accepted in the done cycle.
    frame(0, 8'h3C, 1'b0, len, par);
    chk("b2b_len_a", 32'(len), 32'd44);
    frame(0, 8'hC3, 1'b0, len, par);
    chk("b2b_len_b", 32'(len), 32'd44);
    idle(0, 2);

    // Inputs wiggled mid-frame must not disturb the captured word.
    frame(0, 8'h96, 1'b1, len, par);
    chk("scramble_len0", 32'(len), 32'd44);
    chk("scramble_par0", 32'(par), 32'd0);
    idle(0, 1);
    frame(1, 8'h3B, 1'b1, len, par);
    chk("scramble_len1", 32'(len), 32'd40);
    idle(1, 1);

    // Reset in the middle of data bit 3 aborts the frame asynchronously.
    set_in(0, 1'b1, 8'h55);
    @(negedge clk);
    set_in(0, 1'b0, 8'h00);
    repeat (4*CPB + 1) @(negedge clk);
    chk("pre_abort_state", 32'(stat(0)), 32'b0100);
    #1 reset = 1'b1;
    #1 chk("async_abort", 32'(stat(0)), 32'b1010);
    @(negedge clk);
    reset = 1'b0;
    idle(0, 5);
    frame(0, 8'hFF, 1'b0, len, par);
    chk("after_abort_len", 32'(len), 32'd44);
    chk("after_abort_par", 32'(par), 32'd0);
    idle(0, 1);

    // Random words, random instance, random mid-frame noise and gaps.
    d = 0;
    for (int i = 0; i < 20; i++) begin
      int gap;
      d = int'($urandom_range(0, 1));
      w = 8'($urandom);
      frame(d, w, 1'($urandom_range(0, 1)), len, par);
      chk("rand_len", 32'(len), (d == 0) ? 32'd44 : 32'd40);
      if (d == 0) chk("rand_par", 32'(par), 32'(^w));
      gap = int'($urandom_range(0, 2));
      if (gap > 0) idle(d, gap);
    end
    idle(d, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
